// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: default reset PC,
// the filler word presented on a misaligned-target fault, FSM encodings and
// the sequential PC step helper.
package instr_prefetch_pkg;

    // First fetch address after reset unless overridden at instantiation.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // All-zero word decodes as illegal in the ID stage.
    localparam logic [31:0] FAULT_FILL_WORD = 32'h0000_0000;

    // RUN: normal fetching. FAULT: parked on a misaligned redirect target.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ifu_state_e;

    // Next sequential word address; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Bundle of the prefetch unit's memory-side and decoder-side signals.
// master = the prefetch unit, slave = its environment (imem + ID stage).
interface instr_prefetch_if;

    // instruction memory side
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    // control flow redirect
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    // decoder side
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
        output instr_ready_i
    );

endinterface

// File: rtl/instr_prefetch_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs for the prefetch unit.
// Push and pop in the same cycle are both honoured (also when full);
// clear empties the FIFO and overrides any same-cycle push or pop.
// Storage is not reset; only pointers and occupancy are.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write; a cleared cycle writes nothing.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit for the IF stage.
// Issues sequential word fetches, buffers returned words with their PCs in
// fetch_fifo and hands them to the decoder over valid/ready. A redirect
// flushes the FIFO, marks every in-flight fetch for discard and restarts
// fetching at the new target.
// Optional feature macro: IFU_MISALIGN_FAULT_EN -- when defined, a redirect
// to a non-word-aligned target parks the unit in FAULT and presents a fault
// marker entry until an aligned redirect arrives. When undefined, the low
// two target bits are ignored and instr_fault_o is tied low.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    instr_prefetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_e    r_state;
    ifu_state_e    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_outst_nxt;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [63:0]   w_fifo_head;

    logic [31:0]   w_redir_pc;
    logic          w_redir_misalign;
    logic [CW:0]   w_inflight;
    logic          w_credit_ok;
    logic          w_grant;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

`ifdef IFU_MISALIGN_FAULT_EN
    logic [31:0]   r_fault_pc;

    assign w_redir_pc       = bus.redirect_pc_i;
    assign w_redir_misalign = (bus.redirect_pc_i[1:0] != 2'b00);
`else
    assign w_redir_pc       = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign w_redir_misalign = 1'b0;
`endif

    // Buffered plus outstanding words may never exceed DEPTH, so every
    // returning word is guaranteed a FIFO slot.
    assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outst};
    assign w_credit_ok = !w_fifo_full && (w_inflight < (CW+1)'(DEPTH));

    assign bus.imem_req_o  = (r_state == ST_RUN) && !rst && !bus.redirect_i && w_credit_ok;
    assign bus.imem_addr_o = r_fetch_pc;

    assign w_grant = bus.imem_req_o && bus.imem_gnt_i;
    assign w_drop  = bus.imem_rvalid_i && (r_discard != '0);
    assign w_push  = bus.imem_rvalid_i && !w_drop;
    assign w_pop   = !w_fifo_empty && (r_state == ST_RUN) && bus.instr_ready_i && !bus.redirect_i;

    // Outstanding count after this cycle's grant and response; a redirect
    // turns exactly this many future responses into discards.
    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_grant, bus.imem_rvalid_i})
            2'b10:   w_outst_nxt = r_outst + CW'(1);
            2'b01:   w_outst_nxt = r_outst - CW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Fetch/response PCs and the outstanding/discard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (bus.redirect_i) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_discard  <= w_outst_nxt;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= pc_next(r_fetch_pc);
                end
                if (w_push) begin
                    r_rsp_pc <= pc_next(r_rsp_pc);
                end
                if (w_drop) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: only a redirect moves between RUN and FAULT.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_i) begin
            w_state_nxt = w_redir_misalign ? ST_FAULT : ST_RUN;
        end
    end

`ifdef IFU_MISALIGN_FAULT_EN
    // Capture the faulting target so it can be reported as the entry PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_pc <= '0;
        end else if (bus.redirect_i) begin
            r_fault_pc <= bus.redirect_pc_i;
        end
    end
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, bus.imem_rdata_i}),
        .i_pop   (w_pop),
        .i_clear (bus.redirect_i),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Decoder-facing outputs: FIFO head when non-empty, zeros otherwise,
    // and the held fault marker entry while in FAULT.
    always_comb begin
        bus.instr_valid_o = !w_fifo_empty;
        bus.instr_o       = w_fifo_empty ? 32'h0 : w_fifo_head[31:0];
        bus.instr_pc_o    = w_fifo_empty ? 32'h0 : w_fifo_head[63:32];
        bus.instr_fault_o = 1'b0;
`ifdef IFU_MISALIGN_FAULT_EN
        if (r_state == ST_FAULT) begin
            bus.instr_valid_o = 1'b1;
            bus.instr_o       = FAULT_FILL_WORD;
            bus.instr_pc_o    = r_fault_pc;
            bus.instr_fault_o = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios plus randomized
// traffic against a PC-stream reference model. Honours IFU_MISALIGN_FAULT_EN.
module tb_instr_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_prefetch_if bus();

    instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          grants = 0;
    mreq_t       memq[$];

    // reference model state: next PC the decoder must see, next fetch address
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] fault_pc;
    bit          fault_mode;
    bit          prev_redir;

    // per-cycle samples
    logic        g_req, g_valid, g_fault, g_grant, g_pop;
    logic [31:0] g_addr, g_instr, g_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock cycle: called at a negedge, drives inputs, samples outputs,
    // updates the model, then waits for the next negedge.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit gnt, input bit rdy);
        int unsigned due;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.imem_gnt_i    = gnt;
        bus.instr_ready_i = rdy;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = memq[0].addr ^ KEY;
            void'(memq.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
        #1;
        g_req   = bus.imem_req_o;
        g_addr  = bus.imem_addr_o;
        g_valid = bus.instr_valid_o;
        g_instr = bus.instr_o;
        g_pc    = bus.instr_pc_o;
        g_fault = bus.instr_fault_o;
        g_grant = g_req && gnt;
        g_pop   = g_valid && rdy && !redir;

        if (prev_redir && !fault_mode) check_eq("flush_empty", 32'(g_valid), 32'd0);
`ifdef IFU_MISALIGN_FAULT_EN
        if (fault_mode) begin
            check_eq("fault_valid", 32'(g_valid), 32'd1);
            check_eq("fault_flag", 32'(g_fault), 32'd1);
            check_eq("fault_pc", g_pc, fault_pc);
            check_eq("fault_instr", g_instr, 32'h0);
            check_eq("fault_req", 32'(g_req), 32'd0);
        end else
`endif
        if (g_pop) begin
            check_eq("pop_pc", g_pc, exp_pc);
            check_eq("pop_instr", g_instr, exp_pc ^ KEY);
            check_eq("pop_fault", 32'(g_fault), 32'd0);
            exp_pc = exp_pc + 32'd4;
        end

        if (g_grant) begin
            check_eq("fetch_addr", g_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            grants++;
            due = cyc + 32'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            memq.push_back('{addr: g_addr, due: due});
            check_eq("credit", (memq.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        end

        if (redir) begin
            check_eq("req_in_redir", 32'(g_req), 32'd0);
`ifdef IFU_MISALIGN_FAULT_EN
            fault_mode = (tgt[1:0] != 2'b00);
            fault_pc   = tgt;
`endif
            exp_pc    = tgt & 32'hFFFF_FFFC;
            exp_fetch = tgt & 32'hFFFF_FFFC;
        end
        prev_redir = redir;
        cyc++;
        @(negedge clk);
    endtask

    // Called at a negedge; leaves rst released at a negedge.
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        memq.delete();
        #1;
        check_eq("rst_req", 32'(bus.imem_req_o), 32'd0);
        check_eq("rst_addr", bus.imem_addr_o, RST_PC);
        check_eq("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check_eq("rst_instr", bus.instr_o, 32'h0);
        check_eq("rst_pc", bus.instr_pc_o, 32'h0);
        check_eq("rst_fault", 32'(bus.instr_fault_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        exp_pc     = RST_PC;
        exp_fetch  = RST_PC;
        fault_mode = 1'b0;
        prev_redir = 1'b0;
        last_due   = cyc;
    endtask

    // Steps with gnt/ready high until the first pop, bounded.
    task automatic run_until_pop(input string tag, input logic [31:0] exp, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (g_pop) begin
                found = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, 32'(found), 32'd1);
        if (found) check_eq(tag, g_pc, exp);
    endtask

    initial begin
        logic [31:0] wrap_addr [3];
        int          n_wrap;

        @(negedge clk);

        // streaming from reset: one entry per cycle from cycle 2
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (k == 0) check_eq("first_req", 32'(g_req), 32'd1);
            check_eq("lat_valid", 32'(g_valid), (k >= 2) ? 32'd1 : 32'd0);
        end

        // decoder stalled: credits cap grants at DEPTH
        do_reset();
        grants = 0;
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("stall_grants", 32'(grants), 32'd4);
        check_eq("stall_head_pc", g_pc, 32'h0);
        check_eq("stall_req", 32'(g_req), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("first_pop", 32'(g_pop), 32'd1);
        check_eq("pop_cycle_req", 32'(g_req), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("resume_req", 32'(g_req), 32'd1);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // slow memory, redirect with fetches in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        run_until_pop("redir_first_pc", 32'h0000_0100, 20);
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // redirect coinciding with a response and a pop
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0400, 1'b1, 1'b1);
        check_eq("redir_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
        check_eq("redir_head_valid", 32'(g_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("restart_req", 32'(g_req), 32'd1);
        check_eq("restart_addr", g_addr, 32'h0000_0400);
        run_until_pop("restart_first_pc", 32'h0000_0400, 10);

        // misaligned target
        step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
`ifdef IFU_MISALIGN_FAULT_EN
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, (k % 2) == 0);
        check_eq("fault_held_pc", g_pc, 32'h0000_0102);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        run_until_pop("unfault_first_pc", 32'h0000_0200, 10);
`else
        run_until_pop("misalign_forced_pc", 32'h0000_0100, 10);
`endif

        // address wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        n_wrap = 0;
        for (int k = 0; k < 10 && n_wrap < 3; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (g_grant) begin
                wrap_addr[n_wrap] = g_addr;
                n_wrap++;
            end
        end
        check_eq("wrap_grants", 32'(n_wrap), 32'd3);
        if (n_wrap == 3) begin
            check_eq("wrap_addr0", wrap_addr[0], 32'hFFFF_FFF8);
            check_eq("wrap_addr1", wrap_addr[1], 32'hFFFF_FFFC);
            check_eq("wrap_addr2", wrap_addr[2], 32'h0000_0000);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // randomized traffic
        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            bit          r_redir;
            logic [31:0] r_tgt;
            r_redir = ($urandom_range(99, 0) < 3);
            r_tgt   = $urandom;
            if ($urandom_range(1, 0) == 0) r_tgt = r_tgt & 32'hFFFF_FFFC;
            if ($urandom_range(9, 0) == 0) r_tgt = 32'hFFFF_FFF0;
            if ($urandom_range(999, 0) < 2) do_reset();
            step(r_redir, r_redir ? r_tgt : 32'h0,
                 $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 75);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
